adc_stream_receiver: RTL and testbench
======================================

# adc_stream_receiver

Receive-side endpoint for the ADC capture path. Accepts the packed two-channel AXI-Stream produced by the ADC controller and buffers it in a small FIFO. Unpacks each word into signed 14-bit channel samples, tracks per-channel peak magnitude over a fixed sample window for the IAGC loop, and counts words dropped when an upstream source ignores backpressure.

## Interface
Parameters:
- AXIS_DATA_SIZE, 32, stream word width; ch1 in [31:18], ch2 in [15:2], bits [17:16] and [1:0] ignored
- ZMOD_DATA_SIZE, 14, sample width per channel, two's complement
- FIFO_DEPTH, 16, buffer words; power of two, ≥ 4
- WINDOW_SIZE, 1024, accepted words per peak window; power of two

Ports:
- i_sys_clock  input  1  single clock; all logic on rising edge
- i_reset_n  input  1  synchronous, active-low reset
- i_enable  input  1  level; 1 = accept stream, 0 = stop accepting and drain
- i_axis_tdata  input  AXIS_DATA_SIZE  packed sample word
- i_axis_tvalid  input  1  upstream word valid
- o_axis_tready  output  1  receiver can accept a word this cycle
- o_ch1_sample  output  ZMOD_DATA_SIZE  head-of-FIFO ch1 sample
- o_ch2_sample  output  ZMOD_DATA_SIZE  head-of-FIFO ch2 sample
- o_sample_valid  output  1  head sample present
- i_sample_ready  input  1  consumer takes head sample when o_sample_valid=1
- o_ch1_peak  output  ZMOD_DATA_SIZE-1  ch1 max magnitude of last completed window
- o_ch2_peak  output  ZMOD_DATA_SIZE-1  ch2 max magnitude of last completed window
- o_peak_valid  output  1  one-cycle pulse when peaks update
- o_fifo_level  output  log2(FIFO_DEPTH)+1  words stored
- o_drop_count  output  16  saturating count of words lost to no-tready
- o_busy  output  1  state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN when i_enable=1.
  - RUN → DRAIN when i_enable=0.
  - DRAIN → IDLE when FIFO empty.
  - DRAIN → RUN when i_enable=1 again.
- o_axis_tready = (state==RUN) && (level < FIFO_DEPTH). It is driven from registers only, with no combinational path from i_sample_ready.
- Push on tvalid && tready. Pop on o_sample_valid && i_sample_ready. Push and pop in the same cycle leave the level unchanged.
- Drop: tvalid=1 and tready=0 while state==RUN increments o_drop_count, saturating at 16'hFFFF. Not counted in IDLE or DRAIN.
- Unpack: o_ch1_sample = word[31:18], o_ch2_sample = word[15:2].
- Peak magnitude per accepted word:
  - |x| for x ≥ 0; −x for x < 0.
  - −8192 saturates to 8191, giving a 13-bit result.
  - The running max is kept per channel.
- Window end: after WINDOW_SIZE accepted words (counter wraps WINDOW_SIZE−1 → 0):
  - Publish the running max, including the current word, to o_chN_peak.
  - Pulse o_peak_valid.
  - Running max restarts at 0 with the next word.
- Leaving RUN clears the window counter and running max. A partial window is never published.
- Drained samples remain poppable in DRAIN.

## Timing
- Reset (i_reset_n=0 at an edge):
  - State goes to IDLE.
  - All outputs are 0: tready, sample_valid, ch samples, peaks, peak_valid, fifo_level, drop_count, busy.
  - FIFO contents are discarded.
  - Reset mid-transfer drops buffered data with no further outputs.
- IDLE → RUN: tready rises the cycle after the edge that samples i_enable=1.
- FIFO empty, word accepted at edge k: o_sample_valid=1 with its data after edge k+1.
- Head data and o_sample_valid are held stable until popped.
- Full: tready falls after the edge that makes level=FIFO_DEPTH. It rises after the edge where a pop occurs.
- o_peak_valid is high for exactly the cycle after the edge accepting word number WINDOW_SIZE, then low.
- o_fifo_level is registered and reflects all pushes and pops through the previous edge.

## Test plan
- Reset: hold i_reset_n=0 for 3 cycles with tvalid=1 → every output 0. Release with i_enable=1 → tready=1 one cycle later.
- Unpack: send 0x7FFC_8000 → o_ch1_sample=0x1FFF (+8191), o_ch2_sample=0x2000 (−8192), o_sample_valid high 2 edges after tvalid.
- Backpressure: i_sample_ready=0, FIFO_DEPTH=16, 20 words of continuous tvalid → tready low after 16 accepted, level=16, drop_count=4. Pop one → exactly one more word accepted.
- Peak: WINDOW_SIZE=8 with ch1 values {5,−100,3,0,−8192,7,1,2} → one o_peak_valid pulse after the 8th word, o_ch1_peak=8191. Next window of all zeros → peak=0.
- Drain: deassert i_enable with 5 words buffered → tready=0 at once, o_busy=1 until the 5th pop, then IDLE. No peak published for the partial window.
- Simultaneous push/pop at level=3 for 10 cycles → level stays 3, data order preserved, drop_count=0.

Source files
------------

// File: rtl/adc_stream_receiver_if.sv
// adc_stream_receiver_if: stream input, sample output and status signals of the ADC receive endpoint
interface adc_stream_receiver_if #(
  parameter int AXIS_DATA_SIZE = 32,
  parameter int ZMOD_DATA_SIZE = 14,
  parameter int FIFO_DEPTH     = 16
);
  logic                          i_enable;
  logic [AXIS_DATA_SIZE-1:0]     i_axis_tdata;
  logic                          i_axis_tvalid;
  logic                          o_axis_tready;
  logic [ZMOD_DATA_SIZE-1:0]     o_ch1_sample;
  logic [ZMOD_DATA_SIZE-1:0]     o_ch2_sample;
  logic                          o_sample_valid;
  logic                          i_sample_ready;
  logic [ZMOD_DATA_SIZE-2:0]     o_ch1_peak;
  logic [ZMOD_DATA_SIZE-2:0]     o_ch2_peak;
  logic                          o_peak_valid;
  logic [$clog2(FIFO_DEPTH):0]   o_fifo_level;
  logic [15:0]                   o_drop_count;
  logic                          o_busy;
  modport slave (
    input  i_enable, i_axis_tdata, i_axis_tvalid, i_sample_ready,
    output o_axis_tready, o_ch1_sample, o_ch2_sample, o_sample_valid,
           o_ch1_peak, o_ch2_peak, o_peak_valid, o_fifo_level, o_drop_count, o_busy
  );
  modport master (
    output i_enable, i_axis_tdata, i_axis_tvalid, i_sample_ready,
    input  o_axis_tready, o_ch1_sample, o_ch2_sample, o_sample_valid,
           o_ch1_peak, o_ch2_peak, o_peak_valid, o_fifo_level, o_drop_count, o_busy
  );
endinterface

// File: rtl/adc_stream_receiver.sv
// adc_stream_receiver: buffers packed two-channel ADC words, unpacks samples, tracks windowed peaks and drops
module adc_stream_receiver #(
  parameter int AXIS_DATA_SIZE = 32,
  parameter int ZMOD_DATA_SIZE = 14,
  parameter int FIFO_DEPTH     = 16,
  parameter int WINDOW_SIZE    = 1024
) (
  input logic i_sys_clock,
  input logic i_reset_n,
  adc_stream_receiver_if.slave sif
);
  localparam int ZW = ZMOD_DATA_SIZE;
  localparam int MW = ZW - 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int WW = WINDOW_SIZE > 1 ? $clog2(WINDOW_SIZE) : 1;
  localparam int HB = AXIS_DATA_SIZE / 2;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WLAST = WW'(WINDOW_SIZE - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [2*ZW-1:0] mem_q [FIFO_DEPTH];
  logic [2*ZW-1:0] head_q, head_d, word;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic head_vld_q, head_vld_d;
  logic [15:0] drop_q, drop_d;
  logic [WW-1:0] win_q, win_d;
  logic [MW-1:0] max1_q, max1_d, max2_q, max2_d, pk1_q, pk1_d, pk2_q, pk2_d;
  logic [MW-1:0] mag1, mag2, m1, m2;
  logic pv_q, pv_d, tready, push, pop, load, wrap, run;
  logic unused_pad;
  function automatic logic [MW-1:0] mag(input logic [ZW-1:0] x);
    logic [ZW-1:0] n;
    n = -x;
    return !x[ZW-1] ? x[MW-1:0] : (x == {1'b1, {MW{1'b0}}}) ? {MW{1'b1}} : n[MW-1:0];
  endfunction
  assign unused_pad = ^{sif.i_axis_tdata[AXIS_DATA_SIZE-ZW-1:HB], sif.i_axis_tdata[HB-ZW-1:0]};
  always_comb begin
    run = state_q == RUN;
    word = {sif.i_axis_tdata[AXIS_DATA_SIZE-1 -: ZW], sif.i_axis_tdata[HB-1 -: ZW]};
    tready = run && level_q < FULL;
    push = sif.i_axis_tvalid && tready;
    pop = head_vld_q && sif.i_sample_ready;
    // head register refills from memory whenever it is empty or being consumed
    load = (level_q != LW'(head_vld_q)) && (!head_vld_q || pop);
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(load);
    level_d = level_q + LW'(push) - LW'(pop);
    head_vld_d = load || (head_vld_q && !pop);
    head_d = load ? mem_q[rd_q] : head_q;
    drop_d = (run && sif.i_axis_tvalid && !tready && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    mag1 = mag(word[2*ZW-1:ZW]);
    mag2 = mag(word[ZW-1:0]);
    m1 = mag1 > max1_q ? mag1 : max1_q;
    m2 = mag2 > max2_q ? mag2 : max2_q;
    wrap = push && win_q == WLAST;
    win_d = (!run || wrap) ? '0 : win_q + WW'(push);
    max1_d = (!run || wrap) ? '0 : push ? m1 : max1_q;
    max2_d = (!run || wrap) ? '0 : push ? m2 : max2_q;
    pk1_d = wrap ? m1 : pk1_q;
    pk2_d = wrap ? m2 : pk2_q;
    pv_d = wrap;
    state_d = state_q == IDLE ? (sif.i_enable ? RUN : IDLE) :
              sif.i_enable ? RUN :
              run ? DRAIN :
              level_d == '0 ? IDLE : DRAIN;
  end
  always_ff @(posedge i_sys_clock) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      head_q <= '0;
      head_vld_q <= 1'b0;
      drop_q <= '0;
      win_q <= '0;
      max1_q <= '0;
      max2_q <= '0;
      pk1_q <= '0;
      pk2_q <= '0;
      pv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      head_q <= head_d;
      head_vld_q <= head_vld_d;
      drop_q <= drop_d;
      win_q <= win_d;
      max1_q <= max1_d;
      max2_q <= max2_d;
      pk1_q <= pk1_d;
      pk2_q <= pk2_d;
      pv_q <= pv_d;
    end
  end
  always_ff @(posedge i_sys_clock) begin
    if (i_reset_n && push) mem_q[wr_q] <= word;
  end
  assign sif.o_axis_tready = tready;
  assign sif.o_ch1_sample = head_q[2*ZW-1:ZW];
  assign sif.o_ch2_sample = head_q[ZW-1:0];
  assign sif.o_sample_valid = head_vld_q;
  assign sif.o_ch1_peak = pk1_q;
  assign sif.o_ch2_peak = pk2_q;
  assign sif.o_peak_valid = pv_q;
  assign sif.o_fifo_level = level_q;
  assign sif.o_drop_count = drop_q;
  assign sif.o_busy = state_q != IDLE;
endmodule

// File: tb/tb_adc_stream_receiver.sv
// tb_adc_stream_receiver: table vectors, corner sequences and random traffic against a queue-based model
module tb_adc_stream_receiver;
  logic clk = 1'b0;
  logic rst_n, en, tv, sr;
  logic [31:0] td;
  int nvec = 0, nerr = 0;
  adc_stream_receiver_if #(.AXIS_DATA_SIZE(32), .ZMOD_DATA_SIZE(14), .FIFO_DEPTH(16)) sif ();
  adc_stream_receiver #(.AXIS_DATA_SIZE(32), .ZMOD_DATA_SIZE(14), .FIFO_DEPTH(16), .WINDOW_SIZE(8)) dut (
    .i_sys_clock(clk), .i_reset_n(rst_n), .sif(sif));
  assign sif.i_enable = en;
  assign sif.i_axis_tdata = td;
  assign sif.i_axis_tvalid = tv;
  assign sif.i_sample_ready = sr;
  always #5 clk = ~clk;
  // reference model: 0 idle, 1 run, 2 drain; queue of accepted words with their acceptance edge
  int ms = 0, ecount = 0, drops = 0, pk1 = 0, pk2 = 0;
  bit pv = 0;
  int q[$], qt[$], w1[$], w2[$];
  typedef struct { logic [13:0] c1; logic [13:0] c2; logic [31:0] data; } vec_t;
  vec_t tab [8];
  function automatic int magf(int raw);
    int x;
    x = raw >= 8192 ? raw - 16384 : raw;
    x = x < 0 ? -x : x;
    return x > 8191 ? 8191 : x;
  endfunction
  function automatic int maxq(int w[$]);
    int m = 0;
    foreach (w[i]) if (w[i] > m) m = w[i];
    return m;
  endfunction
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  task automatic tick();
    bit rdy, hv, push, pop;
    rdy = ms == 1 && q.size() < 16;
    hv = q.size() > 0 && qt[0] < ecount;
    @(posedge clk);
    ecount++;
    if (!rst_n) begin
      ms = 0; drops = 0; pk1 = 0; pk2 = 0; pv = 0;
      q.delete(); qt.delete(); w1.delete(); w2.delete();
    end else begin
      pv = 0;
      push = tv && rdy;
      pop = hv && sr;
      if (tv && !rdy && ms == 1 && drops < 65535) drops++;
      if (pop) begin void'(q.pop_front()); void'(qt.pop_front()); end
      if (push) begin
        q.push_back({td[31:18], td[15:2]});
        qt.push_back(ecount);
        w1.push_back(magf(int'(td[31:18])));
        w2.push_back(magf(int'(td[15:2])));
        if (w1.size() == 8) begin
          pk1 = maxq(w1); pk2 = maxq(w2); pv = 1;
          w1.delete(); w2.delete();
        end
      end
      ms = ms == 0 ? (en ? 1 : 0) : en ? 1 : ms == 1 ? 2 : q.size() == 0 ? 0 : 2;
      if (ms != 1) begin w1.delete(); w2.delete(); end
    end
    #1;
    hv = q.size() > 0 && qt[0] < ecount;
    chk("tready", sif.o_axis_tready, ms == 1 && q.size() < 16);
    chk("sample_valid", sif.o_sample_valid, hv);
    if (hv) begin
      chk("ch1_sample", sif.o_ch1_sample, q[0] >> 14);
      chk("ch2_sample", sif.o_ch2_sample, q[0] & 16383);
    end
    chk("fifo_level", sif.o_fifo_level, q.size());
    chk("drop_count", sif.o_drop_count, drops);
    chk("busy", sif.o_busy, ms != 0);
    chk("peak_valid", sif.o_peak_valid, pv);
    chk("ch1_peak", sif.o_ch1_peak, pk1);
    chk("ch2_peak", sif.o_ch2_peak, pk2);
  endtask
  initial begin
    int c1v[8] = '{5, -100, 3, 0, -8192, 7, 1, 2};
    int c2v[8] = '{1, 2, -3, 100, -300, 50, 0, 4};
    foreach (tab[i]) begin
      tab[i].c1 = 14'(c1v[i]);
      tab[i].c2 = 14'(c2v[i]);
      tab[i].data = {tab[i].c1, 2'(i), tab[i].c2, 2'(3 - i % 4)};
    end
    rst_n = 0; en = 1; tv = 1; sr = 0; td = 32'hDEAD_BEEF;
    repeat (3) tick();
    chk("rst tready", sif.o_axis_tready, 0);
    chk("rst valid", sif.o_sample_valid, 0);
    chk("rst ch1", sif.o_ch1_sample, 0);
    chk("rst ch2", sif.o_ch2_sample, 0);
    chk("rst pk1", sif.o_ch1_peak, 0);
    chk("rst pk2", sif.o_ch2_peak, 0);
    chk("rst pv", sif.o_peak_valid, 0);
    chk("rst level", sif.o_fifo_level, 0);
    chk("rst drop", sif.o_drop_count, 0);
    chk("rst busy", sif.o_busy, 0);
    rst_n = 1; tv = 0;
    tick();
    chk("release tready", sif.o_axis_tready, 1);
    td = 32'h7FFC_8000; tv = 1;
    tick();
    tv = 0;
    chk("unpack early valid", sif.o_sample_valid, 0);
    tick();
    chk("unpack valid", sif.o_sample_valid, 1);
    chk("unpack ch1", sif.o_ch1_sample, 14'h1FFF);
    chk("unpack ch2", sif.o_ch2_sample, 14'h2000);
    sr = 1; tick(); sr = 0;
    en = 0; tick(); tick();
    chk("idle busy", sif.o_busy, 0);
    en = 1; tick();
    sr = 1; tv = 1;
    for (int i = 0; i < 8; i++) begin
      td = tab[i].data;
      tick();
      if (i > 0) begin
        chk("table ch1", sif.o_ch1_sample, tab[i-1].c1);
        chk("table ch2", sif.o_ch2_sample, tab[i-1].c2);
      end
      chk("table pv", sif.o_peak_valid, i == 7);
    end
    chk("table pk1", sif.o_ch1_peak, 8191);
    chk("table pk2", sif.o_ch2_peak, 300);
    td = 0;
    tick();
    chk("table last ch1", sif.o_ch1_sample, tab[7].c1);
    chk("pv one cycle", sif.o_peak_valid, 0);
    repeat (7) tick();
    chk("zero pv", sif.o_peak_valid, 1);
    chk("zero pk1", sif.o_ch1_peak, 0);
    chk("zero pk2", sif.o_ch2_peak, 0);
    tv = 0; repeat (3) tick();
    chk("empty level", sif.o_fifo_level, 0);
    sr = 0; tv = 1;
    for (int i = 0; i < 20; i++) begin td = $urandom; tick(); end
    chk("full level", sif.o_fifo_level, 16);
    chk("full drop", sif.o_drop_count, 4);
    chk("full tready", sif.o_axis_tready, 0);
    tv = 0; sr = 1; tick();
    chk("pop tready", sif.o_axis_tready, 1);
    sr = 0; tv = 1; repeat (3) tick();
    chk("refill level", sif.o_fifo_level, 16);
    chk("refill drop", sif.o_drop_count, 6);
    tv = 0; sr = 1; repeat (11) tick();
    chk("pre-drain level", sif.o_fifo_level, 5);
    en = 0; sr = 0; tick();
    chk("drain tready", sif.o_axis_tready, 0);
    chk("drain busy", sif.o_busy, 1);
    sr = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drain busy pop", sif.o_busy, i < 4);
      chk("drain pv", sif.o_peak_valid, 0);
    end
    sr = 0; en = 1; tick();
    tv = 1; repeat (3) begin td = $urandom; tick(); end
    tv = 0; tick();
    sr = 1; tv = 1;
    for (int i = 0; i < 10; i++) begin
      td = $urandom; tick();
      chk("pushpop level", sif.o_fifo_level, 3);
      chk("pushpop drop", sif.o_drop_count, 6);
    end
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 499) != 0;
      en = $urandom_range(0, 19) != 0;
      tv = $urandom_range(0, 3) != 0;
      sr = $urandom_range(0, 2) != 0;
      td = $urandom;
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
